// File: rtl/alu_pkg.sv
// Shared constants, opcode encodings and FSM state type for the ALU port arbiter.
package alu_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned INSTR_W = 37;

    // Instruction bits the ALU implements (bits 18..0).
    localparam logic [INSTR_W-1:0] ALU_OP_MASK = 37'h7FFFF;

    // One-hot opcodes.
    localparam logic [INSTR_W-1:0] OP_ADD   = 37'h00001;
    localparam logic [INSTR_W-1:0] OP_SUB   = 37'h00002;
    localparam logic [INSTR_W-1:0] OP_AND   = 37'h00004;
    localparam logic [INSTR_W-1:0] OP_OR    = 37'h00008;
    localparam logic [INSTR_W-1:0] OP_XOR   = 37'h00010;
    localparam logic [INSTR_W-1:0] OP_SLL   = 37'h00020;
    localparam logic [INSTR_W-1:0] OP_SRL   = 37'h00040;
    localparam logic [INSTR_W-1:0] OP_SRA   = 37'h00080;
    localparam logic [INSTR_W-1:0] OP_SLT   = 37'h00100;
    localparam logic [INSTR_W-1:0] OP_SLTU  = 37'h00200;
    localparam logic [INSTR_W-1:0] OP_ADDI  = 37'h00400;
    localparam logic [INSTR_W-1:0] OP_ANDI  = 37'h00800;
    localparam logic [INSTR_W-1:0] OP_ORI   = 37'h01000;
    localparam logic [INSTR_W-1:0] OP_XORI  = 37'h02000;
    localparam logic [INSTR_W-1:0] OP_SLLI  = 37'h04000;
    localparam logic [INSTR_W-1:0] OP_SRLI  = 37'h08000;
    localparam logic [INSTR_W-1:0] OP_SRAI  = 37'h10000;
    localparam logic [INSTR_W-1:0] OP_SLTI  = 37'h20000;
    localparam logic [INSTR_W-1:0] OP_SLTIU = 37'h40000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on a tie the port that did not win last time is granted.
module rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       last_grant_i,
    output logic       grant_valid_c_o,
    output logic       grant_idx_c_o
);

    // Combinational grant selection.
    always_comb begin
        grant_valid_c_o = |valid_i;
        grant_idx_c_o   = 1'b0;
        unique case (valid_i)
            2'b01:   grant_idx_c_o = 1'b0;
            2'b10:   grant_idx_c_o = 1'b1;
            2'b11:   grant_idx_c_o = ~last_grant_i;
            default: grant_idx_c_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_port_arbiter.sv
// Shares one combinational ALU between two requesters: round-robin accept,
// one-cycle execute, then a back-pressurable response to the owning port.
module alu_port_arbiter
    import alu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [INSTR_W-1:0] req0_instr,
    input  logic [XLEN-1:0]    req0_v1,
    input  logic [XLEN-1:0]    req0_v2,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [INSTR_W-1:0] req1_instr,
    input  logic [XLEN-1:0]    req1_v1,
    input  logic [XLEN-1:0]    req1_v2,
    output logic               rsp0_valid,
    input  logic               rsp0_ready,
    output logic [XLEN-1:0]    rsp0_result,
    output logic               rsp0_err,
    output logic               rsp1_valid,
    input  logic               rsp1_ready,
    output logic [XLEN-1:0]    rsp1_result,
    output logic               rsp1_err,
    output logic [XLEN-1:0]    alu_v1,
    output logic [XLEN-1:0]    alu_v2,
    output logic [INSTR_W-1:0] alu_instr,
    input  logic [XLEN-1:0]    alu_result,
    output logic               busy
);

    state_e             state_q, state_d;
    logic               owner_q, owner_d;
    logic               last_grant_q, last_grant_d;
    logic [XLEN-1:0]    v1_q, v1_d;
    logic [XLEN-1:0]    v2_q, v2_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               illegal_q, illegal_d;
    logic [XLEN-1:0]    result_q, result_d;
    logic               err_q, err_d;

    logic               grant_valid;
    logic               grant_idx;
    logic [INSTR_W-1:0] sel_instr;
    logic               sel_illegal;

    rr_arb2 u_arb (
        .valid_i         ({req1_valid, req0_valid}),
        .last_grant_i    (last_grant_q),
        .grant_valid_c_o (grant_valid),
        .grant_idx_c_o   (grant_idx)
    );

    // Legality of the instruction about to be accepted: exactly one bit, inside the ALU mask.
    assign sel_instr   = grant_idx ? req1_instr : req0_instr;
    assign sel_illegal = (sel_instr == '0)
                      || ((sel_instr & (sel_instr - INSTR_W'(1))) != '0)
                      || ((sel_instr & ~ALU_OP_MASK) != '0);

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            v1_q         <= '0;
            v2_q         <= '0;
            instr_q      <= '0;
            illegal_q    <= 1'b0;
            result_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            v1_q         <= v1_d;
            v2_q         <= v2_d;
            instr_q      <= instr_d;
            illegal_q    <= illegal_d;
            result_q     <= result_d;
            err_q        <= err_d;
        end
    end

    // Next-state: accept in IDLE, capture the ALU in EXEC, wait for handshake in RESP.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        v1_d         = v1_q;
        v2_d         = v2_q;
        instr_d      = instr_q;
        illegal_d    = illegal_q;
        result_d     = result_q;
        err_d        = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    v1_d         = grant_idx ? req1_v1 : req0_v1;
                    v2_d         = grant_idx ? req1_v2 : req0_v2;
                    instr_d      = sel_instr;
                    illegal_d    = sel_illegal;
                    owner_d      = grant_idx;
                    last_grant_d = grant_idx;
                    state_d      = ST_EXEC;
                end
            end
            ST_EXEC: begin
                result_d = illegal_q ? '0 : alu_result;
                err_d    = illegal_q;
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                if (owner_q ? rsp1_ready : rsp0_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Port outputs decoded from the registered state.
    assign req0_ready  = (state_q == ST_IDLE) && !rst && grant_valid && !grant_idx;
    assign req1_ready  = (state_q == ST_IDLE) && !rst && grant_valid &&  grant_idx;
    assign rsp0_valid  = (state_q == ST_RESP) && !owner_q;
    assign rsp1_valid  = (state_q == ST_RESP) &&  owner_q;
    assign rsp0_err    = rsp0_valid && err_q;
    assign rsp1_err    = rsp1_valid && err_q;
    assign rsp0_result = result_q;
    assign rsp1_result = result_q;
    assign alu_v1      = v1_q;
    assign alu_v2      = v2_q;
    assign alu_instr   = ((state_q == ST_EXEC) && !illegal_q) ? instr_q : '0;
    assign busy        = (state_q != ST_IDLE);

endmodule
